// File: rtl/adc_filter_pkg.sv
// ============================================================================
// Module   : adc_filter_pkg
// Brief    : Shared constants and helpers for the ADC moving-average filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adc_filter_pkg;

  localparam int c_DW           = 14;
  localparam int c_AVG_LOG2_DEF = 3;
  localparam int c_SPIKE_TH_DEF = 1024;

  function automatic int sum_width(input int dw, input int avg_log2);
    return dw + avg_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_avg_channel.sv
// ============================================================================
// Module   : adc_avg_channel
// Brief    : One moving-average channel: circular buffer, running sum, output
//            register and optional spike rejection (ADC_SPIKE_REJECT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_avg_channel
  import adc_filter_pkg::*;
#(
  parameter int AVG_LOG2 = c_AVG_LOG2_DEF,
  parameter int DW       = c_DW
`ifdef ADC_SPIKE_REJECT_EN
  ,
  parameter int SPIKE_TH = c_SPIKE_TH_DEF
`endif
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic          i_acc,
  input  logic          i_update,
  input  logic [DW-1:0] i_adc_data,
  output logic [DW-1:0] o_data
);

  localparam int c_WIN = 1 << AVG_LOG2;
  localparam int c_SW  = sum_width(DW, AVG_LOG2);

  logic [DW-1:0]       r_s1_data;
  logic [DW-1:0]       r_buf [c_WIN];
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [c_SW-1:0]     r_sum;
  logic [DW-1:0]       r_data;
  logic [DW-1:0]       w_sample;

`ifdef ADC_SPIKE_REJECT_EN
  localparam logic [DW-1:0] c_TH = DW'(SPIKE_TH);

  logic [DW-1:0] r_last_acc;
  logic [1:0]    r_rej_cnt;
  logic          r_primed;
  logic [DW-1:0] w_diff;
  logic          w_spike;

  assign w_diff   = (i_adc_data >= r_last_acc) ? (i_adc_data - r_last_acc)
                                               : (r_last_acc - i_adc_data);
  // Nothing to compare against until one sample has been accepted.
  assign w_spike  = r_primed && (w_diff > c_TH) && (r_rej_cnt < 2'd2);
  assign w_sample = w_spike ? r_last_acc : i_adc_data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_last_acc <= '0;
      r_rej_cnt  <= '0;
      r_primed   <= 1'b0;
    end else if (i_clear) begin
      r_last_acc <= '0;
      r_rej_cnt  <= '0;
      r_primed   <= 1'b0;
    end else if (i_load) begin
      if (w_spike) begin
        r_rej_cnt <= r_rej_cnt + 2'd1;
      end else begin
        r_last_acc <= i_adc_data;
        r_rej_cnt  <= '0;
        r_primed   <= 1'b1;
      end
    end
  end
`else
  assign w_sample = i_adc_data;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_data <= '0;
      r_wr_ptr  <= '0;
      r_sum     <= '0;
      r_data    <= '0;
      for (int i = 0; i < c_WIN; i++) r_buf[i] <= '0;
    end else if (i_clear) begin
      r_s1_data <= '0;
      r_wr_ptr  <= '0;
      r_sum     <= '0;
      r_data    <= '0;
      for (int i = 0; i < c_WIN; i++) r_buf[i] <= '0;
    end else begin
      if (i_load) r_s1_data <= w_sample;
      if (i_acc) begin
        r_sum           <= r_sum + c_SW'(r_s1_data) - c_SW'(r_buf[r_wr_ptr]);
        r_buf[r_wr_ptr] <= r_s1_data;
        r_wr_ptr        <= r_wr_ptr + AVG_LOG2'(1);
      end
      if (i_update) r_data <= r_sum[c_SW-1:AVG_LOG2];
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/adc_avg_filter.sv
// ============================================================================
// Module   : adc_avg_filter
// Brief    : Two-channel lockstep moving-average filter for the resonant
//            capacitor ADCs. Spike rejection enabled by ADC_SPIKE_REJECT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_avg_filter
  import adc_filter_pkg::*;
#(
  parameter int AVG_LOG2 = c_AVG_LOG2_DEF,
  parameter int DW       = c_DW
`ifdef ADC_SPIKE_REJECT_EN
  ,
  parameter int SPIKE_TH = c_SPIKE_TH_DEF
`endif
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i_sample_en,
  input  logic          i_clear,
  input  logic [DW-1:0] i_adc_data_1,
  input  logic [DW-1:0] i_adc_data_2,
  output logic [DW-1:0] o_filtered_data_out1,
  output logic [DW-1:0] o_filtered_data_out2,
  output logic          o_data_strobe,
  output logic          o_filter_valid
);

  localparam logic [AVG_LOG2:0] c_FILL_FULL = (AVG_LOG2+1)'(1) << AVG_LOG2;

  logic              r_s1_vld;
  logic              r_s2_vld;
  logic              r_strobe;
  logic              r_valid;
  logic [AVG_LOG2:0] r_fill;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_fill   <= '0;
    end else if (i_clear) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_s1_vld <= i_sample_en;
      r_s2_vld <= r_s1_vld;
      r_strobe <= r_s2_vld;
      if (r_s1_vld && (r_fill != c_FILL_FULL)) r_fill <= r_fill + (AVG_LOG2+1)'(1);
      // Fill reached full at this sample's accumulate edge, so it rises with its strobe.
      if (r_s2_vld && (r_fill == c_FILL_FULL)) r_valid <= 1'b1;
    end
  end

  adc_avg_channel #(
    .AVG_LOG2 (AVG_LOG2),
    .DW       (DW)
`ifdef ADC_SPIKE_REJECT_EN
    ,
    .SPIKE_TH (SPIKE_TH)
`endif
  ) u_ch1 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_clear    (i_clear),
    .i_load     (i_sample_en),
    .i_acc      (r_s1_vld),
    .i_update   (r_s2_vld),
    .i_adc_data (i_adc_data_1),
    .o_data     (o_filtered_data_out1)
  );

  adc_avg_channel #(
    .AVG_LOG2 (AVG_LOG2),
    .DW       (DW)
`ifdef ADC_SPIKE_REJECT_EN
    ,
    .SPIKE_TH (SPIKE_TH)
`endif
  ) u_ch2 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_clear    (i_clear),
    .i_load     (i_sample_en),
    .i_acc      (r_s1_vld),
    .i_update   (r_s2_vld),
    .i_adc_data (i_adc_data_2),
    .o_data     (o_filtered_data_out2)
  );

  assign o_data_strobe  = r_strobe;
  assign o_filter_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_adc_avg_filter.sv
// ============================================================================
// Module   : tb_adc_avg_filter
// Brief    : Scoreboard bench for adc_avg_filter against a window-average model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc_avg_filter;

  localparam int WIN = 8;
  localparam int TH  = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        clear = 1'b0;
  logic [13:0] adc1 = '0;
  logic [13:0] adc2 = '0;
  logic [13:0] out1;
  logic [13:0] out2;
  logic        strobe;
  logic        fvalid;

  adc_avg_filter dut (
    .sys_clk              (sys_clk),
    .sys_rst_n            (sys_rst_n),
    .i_sample_en          (sample_en),
    .i_clear              (clear),
    .i_adc_data_1         (adc1),
    .i_adc_data_2         (adc2),
    .o_filtered_data_out1 (out1),
    .o_filtered_data_out2 (out2),
    .o_data_strobe        (strobe),
    .o_filter_valid       (fvalid)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int o1;
    int o2;
    bit v;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: accepted-sample history per channel plus spike state.
  int hist1[$];
  int hist2[$];
  int n_acc;
  int last_acc[2];
  int rej_cnt[2];
  bit primed[2];
  int hold1, hold2;
  bit holdv;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist1.delete();
    hist2.delete();
    exp_q.delete();
    n_acc = 0;
    for (int c = 0; c < 2; c++) begin
      last_acc[c] = 0;
      rej_cnt[c]  = 0;
      primed[c]   = 1'b0;
    end
    hold1 = 0;
    hold2 = 0;
    holdv = 1'b0;
  endtask

  function automatic int spike_filt(input int ch, input int s);
`ifdef ADC_SPIKE_REJECT_EN
    int d;
    d = (s > last_acc[ch]) ? s - last_acc[ch] : last_acc[ch] - s;
    if (primed[ch] && d > TH && rej_cnt[ch] < 2) begin
      rej_cnt[ch]++;
      return last_acc[ch];
    end
`endif
    last_acc[ch] = s;
    rej_cnt[ch]  = 0;
    primed[ch]   = 1'b1;
    return s;
  endfunction

  function automatic int window_mean(input int h[$]);
    int s = 0;
    foreach (h[i]) s += h[i];
    return s / WIN;
  endfunction

  // One clock of stimulus; the model is advanced once the edge has taken it.
  task automatic drive(input bit en, input bit clr, input int d1, input int d2);
    exp_t e;
    sample_en = en;
    clear     = clr;
    adc1      = 14'(d1);
    adc2      = 14'(d2);
    @(posedge sys_clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (en) begin
      hist1.push_back(spike_filt(0, d1));
      hist2.push_back(spike_filt(1, d2));
      if (hist1.size() > WIN) void'(hist1.pop_front());
      if (hist2.size() > WIN) void'(hist2.pop_front());
      if (n_acc < WIN) n_acc++;
      e.o1 = window_mean(hist1);
      e.o2 = window_mean(hist2);
      e.v  = (n_acc == WIN);
      e.at = cyc + 2;
      exp_q.push_back(e);
    end
    sample_en = 1'b0;
    clear     = 1'b0;
  endtask

  // Monitor: pops on every strobe, otherwise checks that outputs hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) continue;
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        check("missing_strobe", cyc, e.at);
      end
      if (strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out1", int'(out1), e.o1);
          check("out2", int'(out2), e.o2);
          check("filter_valid", int'(fvalid), int'(e.v));
          check("latency", cyc, e.at);
          hold1 = e.o1;
          hold2 = e.o2;
          holdv = e.v;
        end
      end else begin
        check("hold_out1", int'(out1), hold1);
        check("hold_out2", int'(out2), hold2);
        check("hold_valid", int'(fvalid), int'(holdv));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge sys_clk);
    check("rst_out1", int'(out1), 0);
    check("rst_out2", int'(out2), 0);
    check("rst_strobe", int'(strobe), 0);
    check("rst_valid", int'(fvalid), 0);
    #1;
    sys_rst_n = 1'b1;

    // Ramp: 8 samples of 8000 on ch1 with idle gaps.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8000, $urandom_range(0, 16383));
      repeat (i % 3) drive(0, 0, 0, 0);
    end
    repeat (4) drive(0, 0, 0, 0);

    // Isolated spike on a steady level.
    for (int i = 0; i < 10; i++) drive(1, 0, 8192, 8192);
    drive(1, 0, 16000, 8192);
    for (int i = 0; i < 10; i++) drive(1, 0, 8192, 8192);

    // Sustained step.
    for (int i = 0; i < 12; i++) drive(1, 0, 16000, 8192);
    repeat (3) drive(0, 0, 0, 0);

    // Back-to-back incrementing data.
    for (int i = 0; i < 20; i++) drive(1, 0, 100 + 37 * i, 5000 - 53 * i);

    // Clear at stage 1 of an in-flight sample, with a new sample the same cycle.
    drive(1, 0, 3000, 4000);
    drive(1, 1, 12000, 12000);
    check("clr_out1", int'(out1), 0);
    check("clr_out2", int'(out2), 0);
    check("clr_valid", int'(fvalid), 0);
    repeat (4) drive(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(1, 0, 8000, 800);

    // Full-scale on both, then channel independence.
    for (int i = 0; i < 10; i++) drive(1, 0, 16383, 16383);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 16383);
    repeat (3) drive(0, 0, 0, 0);

    // Reset mid-pipeline aborts in-flight samples.
    drive(1, 0, 5000, 6000);
    drive(1, 0, 5000, 6000);
    sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk);
    #1;
    check("arst_out1", int'(out1), 0);
    check("arst_valid", int'(fvalid), 0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, 0, 2000, 2500);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0)
        drive($urandom_range(0, 1) == 1, 1, $urandom_range(0, 16383), $urandom_range(0, 16383));
      else if ($urandom_range(0, 3) == 0)
        drive(1, 0, $urandom_range(0, 16383), $urandom_range(0, 16383));
      else
        drive($urandom_range(0, 1) == 1, 0,
              6000 + $urandom_range(0, 1500), 9000 + $urandom_range(0, 1500));
    end

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        drive(0, 0, 0, 0);
        budget--;
      end
      if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    end
    repeat (2) drive(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_avg_filter.md
# adc_avg_filter

Two-channel moving-average filter between the capacitor-voltage ADC front end and the capacitor-voltage monitor. It takes raw 14-bit offset-binary samples for resonant capacitor 1 and 2 and produces `filtered_data_out1/2` (truncated mean of the last 2^AVG_LOG2 samples) for the monitor's voltage scaling and threshold compare. Optional spike rejection suppresses isolated IGBT switching transients.

## Interface
- `AVG_LOG2`, 3: log2 of window length (window = 8 samples); legal 1..5.
- `DW`, 14: sample width.
- `SPIKE_TH`, 1024: spike-rejection threshold in ADC codes (used only with `ADC_SPIKE_REJECT_EN`).

- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `sample_en`  in  1  one-cycle strobe: `adc_data_1/2` valid this cycle.
- `clear`  in  1  synchronous flush of both channels.
- `adc_data_1`  in  DW  raw ADC code, cap 1 (0 = -full scale, 16383 = +full scale).
- `adc_data_2`  in  DW  raw ADC code, cap 2.
- `filtered_data_out1`  out  DW  windowed mean, cap 1.
- `filtered_data_out2`  out  DW  windowed mean, cap 2.
- `data_strobe`  out  1  one-cycle pulse when the outputs update.
- `filter_valid`  out  1  high once a full window has been accepted.

## Operation
- Each channel has a circular buffer of 2^AVG_LOG2 DW-bit registers, a write pointer, a running sum of DW+AVG_LOG2 bits, and a fill counter.
- Stage 0 (edge where `sample_en`=1): the sample, after optional spike substitution, is registered into `s1_data`, and `s1_vld` is set.
- Stage 1: `sum <= sum + s1_data - buf[wr_ptr]`, `buf[wr_ptr] <= s1_data`, `wr_ptr` increments with natural wrap at 2^AVG_LOG2, and `fill` saturates at 2^AVG_LOG2.
- Stage 2: `filtered_data_outN <= sum >> AVG_LOG2` (floor, never rounded), and `data_strobe` is asserted.
- Both channels run in lockstep and share `sample_en`, `data_strobe` and `filter_valid`.
- Before the window fills, empty slots hold 0, so the output ramps up: after k samples of value V, the output is floor(k·V / 2^AVG_LOG2).
- `filter_valid` rises in the same cycle as the `data_strobe` of the 2^AVG_LOG2-th accepted sample. It stays high until `clear` or reset.
- The sum cannot overflow: 2^AVG_LOG2 × 16383 fits in DW+AVG_LOG2 bits.
- `clear` zeroes the buffers, sum, pointers, fill, pipeline valids, outputs, `filter_valid` and spike state in one cycle.
  - `clear` has priority over `sample_en` in the same cycle; that sample is dropped.
  - Samples already in stages 1–2 are discarded, and no `data_strobe` follows them.
- Reset values: all outputs 0, `data_strobe` 0, `filter_valid` 0; all internal state 0.
- Reset asserted mid-pipeline aborts all in-flight samples.

## Timing
- Latency from the `sample_en` edge (E0) to the output update is 2 clocks: outputs and `data_strobe` are visible after E2.
- `sample_en` on every cycle is fully supported; throughput is one sample per clock.
- Outputs hold their value between strobes.
- `data_strobe` is exactly one cycle wide per accepted sample.

## Configuration
- `ADC_SPIKE_REJECT_EN` defined:
  - Each channel keeps `last_acc`, the last accepted sample, and a 2-bit `rej_cnt`.
  - If |sample − `last_acc`| > `SPIKE_TH` and `rej_cnt` < 2, the sample is replaced by `last_acc` and `rej_cnt` increments.
  - Otherwise the sample is used as-is, `last_acc` takes its value, and `rej_cnt` clears. A sustained step is therefore accepted on its 3rd sample.
  - The first sample after reset or `clear` is always accepted.
  - Latency is unchanged.
- `ADC_SPIKE_REJECT_EN` undefined: raw samples are used, and the spike logic is absent.

## Structure
- Package `adc_filter_pkg` holds:
  - the DW=14 constant;
  - the default AVG_LOG2 and SPIKE_TH;
  - the sum-width function (DW+AVG_LOG2).
- Sub-module `adc_avg_channel` implements one channel (buffer, sum, spike logic) and is instantiated twice.
- The top level holds the shared control: pipeline valids, fill counter, `data_strobe` and `filter_valid`.

## Test plan
- After reset, 8 strobes of 8000 on ch1 -> first strobe output 1000 with `filter_valid`=0; 8th strobe output 8000 with `filter_valid`=1; first output 2 clocks after the first `sample_en`.
- Steady 8192, then a single 16000 sample -> with the macro, output stays 8192; without it, output becomes 9168 for 8 strobes, then returns to 8192.
- With the macro: steady 8192, then 16000 held -> first two outputs 8192; from the 3rd, the output climbs 9168, 10144, … and reaches 16000 after 8 accepted samples.
- `sample_en` on 20 consecutive cycles with incrementing data -> 20 `data_strobe` pulses on consecutive cycles; each output equals the floor mean of the previous 8 inputs.
- `clear` asserted at stage 1 of an in-flight sample, with `sample_en` high in the same cycle -> next cycle outputs are 0 and `filter_valid`=0, and no `data_strobe` follows; refill behaves as after reset.
- All samples 16383 on both channels -> outputs 16383, no wrap; ch2 is independent of ch1 (ch1=0 while ch2=16383).
